// File: rtl/ifu_inst_queue_if.sv
// ----------------------------------------------------------------------------
// ifu_inst_queue_if -- fetch-to-decode handshake bundle for the instruction
// queue.
//   Fetch side : ifu_valid, ifu_ready, ifu_pc, ifu_inst, ifu_err
//   Decode side: dec_valid, dec_ready, dec_pc, dec_inst, dec_err
// Modports:
//   master -- the surrounding pipeline (drives fetch offers, decode ready)
//   slave  -- the queue itself
// PC width comes from `HiCore_PC_SIZE (defaults to 32 when not set).
// ----------------------------------------------------------------------------
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif

interface ifu_inst_queue_if;
    logic                       ifu_valid;
    logic                       ifu_ready;
    logic [`HiCore_PC_SIZE-1:0] ifu_pc;
    logic [31:0]                ifu_inst;
    logic                       ifu_err;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [`HiCore_PC_SIZE-1:0] dec_pc;
    logic [31:0]                dec_inst;
    logic                       dec_err;

    modport master (
        output ifu_valid, ifu_pc, ifu_inst, ifu_err, dec_ready,
        input  ifu_ready, dec_valid, dec_pc, dec_inst, dec_err
    );

    modport slave (
        input  ifu_valid, ifu_pc, ifu_inst, ifu_err, dec_ready,
        output ifu_ready, dec_valid, dec_pc, dec_inst, dec_err
    );
endinterface

// File: rtl/ifu_inst_queue.sv
// ----------------------------------------------------------------------------
// ifu_inst_queue -- circular instruction queue between fetch and decode.
// Each entry holds {pc, inst, err}; entries leave in push order and the head
// entry is presented combinationally to decode.
// Ports:
//   clk       core clock, all state on rising edge
//   rst_n     asynchronous active-low reset (clears pointers, level, storage)
//   flush     discards every entry (and any same-cycle push) on next edge
//   bus       ifu_inst_queue_if.slave: fetch offer / decode head handshake
//   ifq_level current occupancy, 0..DEPTH
// Parameter DEPTH: 2, 4 or 8 entries.
// Optional feature: define HICORE_IFQ_BYPASS_EN to add a zero-latency path
// from fetch straight to decode while the queue is empty.
// ----------------------------------------------------------------------------
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif

module ifu_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    ifu_inst_queue_if.slave              bus,
    output logic [$clog2(DEPTH):0]       ifq_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PC_W  = `HiCore_PC_SIZE;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [PC_W-1:0]  pc_q   [DEPTH];
    logic [PC_W-1:0]  pc_d   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic             err_q  [DEPTH];
    logic             err_d  [DEPTH];

    logic empty;
    logic push;
    logic pop;
    logic byp_take;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty         = (level_q == '0);
    assign bus.ifu_ready = (level_q < LVL_W'(DEPTH));
    assign ifq_level     = level_q;

`ifdef HICORE_IFQ_BYPASS_EN
    // While empty and not flushing, decode sees the fetch offer directly; a
    // word consumed this way never touches storage.
    logic byp;
    assign byp           = empty && !flush;
    assign bus.dec_valid = byp ? bus.ifu_valid : (!empty && !flush);
    assign bus.dec_pc    = byp ? bus.ifu_pc    : pc_q[rd_ptr_q];
    assign bus.dec_inst  = byp ? bus.ifu_inst  : inst_q[rd_ptr_q];
    assign bus.dec_err   = byp ? bus.ifu_err   : err_q[rd_ptr_q];
    assign byp_take      = byp && bus.ifu_valid && bus.dec_ready;
`else
    assign bus.dec_valid = !empty && !flush;
    assign bus.dec_pc    = pc_q[rd_ptr_q];
    assign bus.dec_inst  = inst_q[rd_ptr_q];
    assign bus.dec_err   = err_q[rd_ptr_q];
    assign byp_take      = 1'b0;
`endif

    // ifu_ready is low at full, so a pop in the same cycle cannot make room.
    assign push = bus.ifu_valid && bus.ifu_ready && !flush && !byp_take;
    // Only a stored head can be popped; a bypassed word is not in storage.
    assign pop  = bus.dec_valid && bus.dec_ready && !empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        err_d    = err_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                pc_d[wr_ptr_q]   = bus.ifu_pc;
                inst_d[wr_ptr_q] = bus.ifu_inst;
                err_d[wr_ptr_q]  = bus.ifu_err;
                wr_ptr_d         = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_ifu_inst_queue.sv
`ifndef HiCore_PC_SIZE
`define HiCore_PC_SIZE 32
`endif

module tb_ifu_inst_queue;
    localparam int DEPTH = 4;
    localparam int PCW   = `HiCore_PC_SIZE;
    localparam int LVLW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [31:0]    inst;
        logic           err;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [LVLW-1:0] ifq_level;

    ifu_inst_queue_if bus ();

    ifu_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .ifq_level (ifq_level)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    int   n_vec = 0;
    int   n_bad = 0;
`ifdef HICORE_IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the current model contents and the applied inputs.
    task automatic check_outputs();
        logic           exp_v;
        ent_t           exp_e;
        exp_e = '0;
        chk("ifq_level", 64'(ifq_level), 64'(mq.size()));
        chk("ifu_ready", 64'(bus.ifu_ready), 64'(mq.size() < DEPTH));
        if (BYP && mq.size() == 0 && !flush) begin
            exp_v = bus.ifu_valid;
            exp_e = '{pc: bus.ifu_pc, inst: bus.ifu_inst, err: bus.ifu_err};
        end else begin
            exp_v = (mq.size() > 0) && !flush;
            if (mq.size() > 0) exp_e = mq[0];
        end
        chk("dec_valid", 64'(bus.dec_valid), 64'(exp_v));
        if (exp_v) begin
            chk("dec_pc",   64'(bus.dec_pc),   64'(exp_e.pc));
            chk("dec_inst", 64'(bus.dec_inst), 64'(exp_e.inst));
            chk("dec_err",  64'(bus.dec_err),  64'(exp_e.err));
        end
    endtask

    // Queue behaviour at the coming edge, from the rules in plain terms.
    task automatic model_step();
        bit do_pop, do_push;
        if (flush) begin
            mq.delete();
        end else if (BYP && mq.size() == 0 && bus.ifu_valid && bus.dec_ready) begin
            // consumed straight through, nothing stored
        end else begin
            do_pop  = (mq.size() > 0) && bus.dec_ready;
            do_push = bus.ifu_valid && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{pc: bus.ifu_pc, inst: bus.ifu_inst, err: bus.ifu_err});
        end
    endtask

    task automatic cycle(input logic v, input logic [PCW-1:0] pc, input logic [31:0] inst,
                         input logic err, input logic rdy, input logic fl);
        @(negedge clk);
        bus.ifu_valid = v;
        bus.ifu_pc    = pc;
        bus.ifu_inst  = inst;
        bus.ifu_err   = err;
        bus.dec_ready = rdy;
        flush         = fl;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic idle();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.ifu_valid = 1'b0;
        bus.ifu_pc    = '0;
        bus.ifu_inst  = '0;
        bus.ifu_err   = 1'b0;
        bus.dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        // Reset state
        chk("rst_level",     64'(ifq_level),     64'd0);
        chk("rst_ifu_ready", 64'(bus.ifu_ready), 64'd1);
        chk("rst_dec_valid", 64'(bus.dec_valid), 64'd0);
        chk("rst_dec_pc",    64'(bus.dec_pc),    64'd0);
        chk("rst_dec_inst",  64'(bus.dec_inst),  64'd0);
        chk("rst_dec_err",   64'(bus.dec_err),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Fill with four words, decode stalled; a fifth is refused
        for (int i = 0; i < 4; i++) cycle(1'b1, PCW'(4 * i), 32'hA000_0000 + i, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, PCW'(32'h10), 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        chk("full_ifu_ready", 64'(bus.ifu_ready), 64'd0);
        // Drain in order
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("drained_valid", 64'(bus.dec_valid), 64'd0);

        // Steady push/pop across pointer wrap
        cycle(1'b1, PCW'(32'h200), 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, PCW'(32'h204), 32'h2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, PCW'(32'h208 + 4 * i), 32'h10 + i, 1'b0, 1'b1, 1'b0);
        chk("stream_level", 64'(ifq_level), 64'd2);

        // Flush with two held and a same-cycle offer of 0x100
        cycle(1'b1, PCW'(32'h100), 32'h0BAD_0100, 1'b0, 1'b0, 1'b1);
        chk("flush_dec_valid", 64'(bus.dec_valid), 64'd0);
        idle();
        chk("post_flush_level", 64'(ifq_level), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Error flag travels with its own pc only
        cycle(1'b1, PCW'(32'h1C), 32'h111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, PCW'(32'h20), 32'h222, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, PCW'(32'h24), 32'h333, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Empty queue, offer and consume together
        cycle(1'b1, PCW'(32'h40), 32'h4040, 1'b0, 1'b1, 1'b0);
        chk("byp_same_cycle_valid", 64'(bus.dec_valid), 64'(BYP));
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("byp_next_cycle_valid", 64'(bus.dec_valid), 64'(!BYP));
        idle();

        // Asynchronous reset mid-operation
        cycle(1'b1, PCW'(32'h300), 32'h3, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, PCW'(32'h304), 32'h4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.ifu_valid = 1'b0;
        bus.ifu_pc    = '0;
        bus.ifu_inst  = '0;
        bus.ifu_err   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(ifq_level),     64'd0);
        chk("async_rst_valid", 64'(bus.dec_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.ifu_ready), 64'd1);
        chk("async_rst_pc",    64'(bus.dec_pc),    64'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Randomized traffic with phases biased toward full and toward empty
        for (int i = 0; i < 600; i++) begin
            int  phase;
            logic rdy;
            phase = (i / 50) % 3;
            case (phase)
                0:       rdy = ($urandom_range(0, 3) == 0);
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = $urandom_range(0, 1);
            endcase
            cycle(($urandom_range(0, 9) < 7), PCW'($urandom) & ~PCW'(3), $urandom,
                  $urandom_range(0, 1), rdy, ($urandom_range(0, 24) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ifu_inst_queue.md
IFU_INST_QUEUE -- requirements
Module: ifu_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; legal values 2, 4, 8.
REQ-002 SHALL have port clk, input, 1 bit, core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1 bit, pipeline flush from execute or trap logic.
REQ-005 SHALL have port ifu_valid, input, 1 bit, fetch unit offers an instruction.
REQ-006 SHALL have port ifu_ready, output, 1 bit, queue accepts the offered instruction.
REQ-007 SHALL have port ifu_pc, input, `HiCore_PC_SIZE bits, PC of the offered instruction.
REQ-008 SHALL have port ifu_inst, input, 32 bits, instruction word.
REQ-009 SHALL have port ifu_err, input, 1 bit, fetch bus error for this word.
REQ-010 SHALL have port dec_valid, output, 1 bit, queue head is presented to decode.
REQ-011 SHALL have port dec_ready, input, 1 bit, decode consumes the head.
REQ-012 SHALL have ports dec_pc, dec_inst, dec_err, outputs, `HiCore_PC_SIZE, 32 and 1 bits, head entry fields.
REQ-013 SHALL have port ifq_level, output, $clog2(DEPTH)+1 bits, current occupancy.

Function
REQ-014 Push SHALL occur when ifu_valid && ifu_ready && !flush; pop SHALL occur when dec_valid && dec_ready.
REQ-015 Storage SHALL be a circular buffer; read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 ifu_ready SHALL be 1 iff ifq_level < DEPTH; there is no push at full, even with a simultaneous pop.
REQ-017 dec_valid SHALL be 1 iff ifq_level > 0 and flush = 0.
REQ-018 dec_pc, dec_inst and dec_err SHALL be driven from the read-pointer entry with no added register stage.
REQ-019 Simultaneous push and pop SHALL leave ifq_level unchanged; push-only SHALL add 1; pop-only SHALL subtract 1.
REQ-020 When flush = 1, the next edge SHALL set both pointers and ifq_level to 0; any push in that cycle SHALL be discarded.
REQ-021 Entries SHALL leave in push order, with pc, inst and err kept together unaltered.
REQ-022 Latency from push to dec_valid SHALL be 1 cycle when REQ-028 bypass is not compiled in.

Reset
REQ-023 While rst_n = 0, pointers and ifq_level SHALL be 0 and all storage fields SHALL be 0.
REQ-024 After reset, dec_valid SHALL be 0, dec_pc/dec_inst/dec_err SHALL be 0, and ifu_ready SHALL be 1.
REQ-025 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-026 Macro HICORE_IFQ_BYPASS_EN SHALL select whether a zero-latency bypass path is compiled in.
REQ-027 Without HICORE_IFQ_BYPASS_EN, behaviour SHALL be exactly REQ-014..REQ-022.
REQ-028 With HICORE_IFQ_BYPASS_EN, when ifq_level = 0 and flush = 0, the queue SHALL behave as follows:
- dec_valid SHALL equal ifu_valid.
- dec_pc, dec_inst and dec_err SHALL equal the ifu_* inputs combinationally.
- If dec_ready = 1, the word SHALL be consumed in the same cycle and not written to storage.
- If dec_ready = 0, the word SHALL be written normally.
REQ-029 With HICORE_IFQ_BYPASS_EN, all behaviour when ifq_level > 0 SHALL be identical to the non-bypass build.

Verification
REQ-030 Reset, then push pc 0x0/0x4/0x8/0xC with dec_ready = 0 -> ifq_level = 4, ifu_ready = 0; a fifth push is refused.
REQ-031 Full queue, then dec_ready = 1 for 4 cycles -> dec_pc = 0x0, 0x4, 0x8, 0xC in order; ifq_level = 0; dec_valid = 0.
REQ-032 Continuous push and pop for 10 words -> pointers wrap; ifq_level stays constant; pc sequence is intact.
REQ-033 Two entries held, flush = 1 together with ifu_valid (pc 0x100) -> same cycle dec_valid = 0; next cycle ifq_level = 0; 0x100 never appears.
REQ-034 ifu_err = 1 on pc 0x20 -> dec_err = 1 only when dec_pc = 0x20.
REQ-035 HICORE_IFQ_BYPASS_EN defined, empty queue, ifu_valid = dec_ready = 1, pc 0x40 -> dec_valid = 1 with dec_pc = 0x40 in the same cycle and ifq_level stays 0; macro undefined -> dec_valid rises one cycle later.
